// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: streams round keys 0..NUM_ROUNDS
// over a valid/ready handshake, one per cycle, with four shared S-boxes.

module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as addr^254 (maps 0 to 0), then the affine map
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, addr);
    end
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

module key_schedule_iter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [DATA_WIDTH-1:0] key_in,
  output logic                  key_ready,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [DATA_WIDTH-1:0] rk_out,
  output logic [3:0]            rk_index,
  output logic                  done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rk_q, rk_d;
  logic [3:0]            idx_q, idx_d;
  logic                  done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .addr (rot[8*g +: 8]),
      .dout (sub[8*g +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          rk_d    = key_in;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_d  = {n0, n1, n2, n3};
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign rk_out    = rk_q;
  assign rk_index  = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Self-checking bench for key_schedule_iter against a FIPS-197 style
// word-array key expansion model using a table S-box.

module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [127:0] sched_t [11];

  always #5 clk = ~clk;

  key_schedule_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_index  (rk_index),
    .done      (done)
  );

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic void expand(input logic [127:0] key, output sched_t rk);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    #3;
    n_tests++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== '0 ||
        rk_index !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got kr=%b v=%b rk=%h idx=%0d done=%b, want 1 0 0 0 0",
               key_ready, rk_valid, rk_out, rk_index, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_key(input logic [127:0] key, input logic [127:0] want1,
                                input logic [127:0] want10, input string tag);
    sched_t s;
    logic [127:0] got1, got10;
    expand(key, s);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = key;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk_out !== s[i] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_rk%0d: got v=%b idx=%0d rk=%h done=%b, want idx=%0d rk=%h",
                 tag, i, rk_valid, rk_index, rk_out, done, i, s[i]);
      end
      if (i == 1) got1 = rk_out;
      if (i == 10) got10 = rk_out;
      @(negedge clk);
    end
    n_tests++;
    if (got1 !== want1 || got10 !== want10) begin
      n_fail++;
      $display("FAIL %s_vector: got rk1=%h rk10=%h, want %h %h", tag, got1, got10, want1, want10);
    end
    n_tests++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b v=%b kr=%b, want 1 0 1", tag, done, rk_valid, key_ready);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: got done=%b, want 0", tag, done);
    end
  endtask

  task automatic test_stall();
    sched_t s;
    logic [127:0] key, hold_rk;
    logic [3:0] hold_idx;
    logic was_stall;
    int k, cyc, stall4;
    key = rand_key();
    expand(key, s);
    k = 0; cyc = 0; stall4 = 0; was_stall = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = key;
    rk_ready  = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    while (k <= 10 && cyc < 300) begin
      if (rk_valid) begin
        if (was_stall) begin
          n_tests++;
          if (rk_out !== hold_rk || rk_index !== hold_idx) begin
            n_fail++;
            $display("FAIL stall_hold: got idx=%0d rk=%h, want idx=%0d rk=%h",
                     rk_index, rk_out, hold_idx, hold_rk);
          end
        end
        hold_rk  = rk_out;
        hold_idx = rk_index;
        if (rk_index == 4'd4 && stall4 < 3) begin
          rk_ready = 1'b0;
          stall4++;
        end else begin
          rk_ready = ($urandom_range(0, 2) != 0);
        end
        if (rk_ready) begin
          n_tests++;
          if (rk_index !== 4'(k) || rk_out !== s[k]) begin
            n_fail++;
            $display("FAIL stall_seq%0d: got idx=%0d rk=%h, want idx=%0d rk=%h",
                     k, rk_index, rk_out, k, s[k]);
          end
          k++;
          was_stall = 1'b0;
        end else begin
          was_stall = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (k <= 10 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_end: got keys=%0d done=%b, want 11 1", k, done);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_key_during_emit();
    sched_t sa, sb;
    logic [127:0] ka, kb;
    ka = rand_key();
    kb = rand_key();
    expand(ka, sa);
    expand(kb, sb);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = ka;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_in = kb;
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (key_ready !== 1'b0 || rk_index !== 4'(i) || rk_out !== sa[i]) begin
        n_fail++;
        $display("FAIL emit_ignore%0d: got kr=%b idx=%0d rk=%h, want kr=0 idx=%0d rk=%h",
                 i, key_ready, rk_index, rk_out, i, sa[i]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (done !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL emit_done: got done=%b kr=%b, want 1 1", done, key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk_out !== sb[i]) begin
        n_fail++;
        $display("FAIL emit_second%0d: got v=%b idx=%0d rk=%h, want idx=%0d rk=%h",
                 i, rk_valid, rk_index, rk_out, i, sb[i]);
      end
      @(negedge clk);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    sched_t s;
    logic [127:0] key;
    logic saw_done;
    int cyc;
    key = rand_key();
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = key;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    cyc = 0;
    while (rk_index !== 4'd6 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (rk_index !== 4'd6) begin
      n_fail++;
      $display("FAIL rstmid_reach6: got idx=%0d, want 6", rk_index);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_out !== '0 ||
        rk_index !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%b kr=%b rk=%h idx=%0d done=%b, want 0 1 0 0 0",
               rk_valid, key_ready, rk_out, rk_index, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || rk_valid === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got activity=%b, want 0", saw_done);
    end
    key = rand_key();
    expand(key, s);
    key_valid = 1'b1;
    key_in    = key;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk_out !== s[i]) begin
        n_fail++;
        $display("FAIL rstmid_restart%0d: got v=%b idx=%0d rk=%h, want idx=%0d rk=%h",
                 i, rk_valid, rk_index, rk_out, i, s[i]);
      end
      @(negedge clk);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    sched_t sa, sb;
    logic [127:0] ka, kb;
    logic exp_v, exp_d;
    logic [3:0] exp_i;
    logic [127:0] exp_rk;
    ka = rand_key();
    kb = rand_key();
    expand(ka, sa);
    expand(kb, sb);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = ka;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_in = kb;
    for (int j = 0; j <= 23; j++) begin
      if (j == 12) key_valid = 1'b0;
      exp_v  = (j != 11 && j != 23);
      exp_d  = (j == 11 || j == 23);
      exp_i  = (j <= 10) ? 4'(j) : 4'(j - 12);
      exp_rk = (j <= 10) ? sa[j] : ((j >= 12 && j <= 22) ? sb[j-12] : rk_out);
      n_tests++;
      if (rk_valid !== exp_v || done !== exp_d ||
          (exp_v && (rk_index !== exp_i || rk_out !== exp_rk))) begin
        n_fail++;
        $display("FAIL b2b_step%0d: got v=%b d=%b idx=%0d rk=%h, want v=%b d=%b idx=%0d rk=%h",
                 j, rk_valid, done, rk_index, rk_out, exp_v, exp_d, exp_i, exp_rk);
      end
      @(negedge clk);
    end
    rk_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    test_reset();
    test_known_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                   128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                   128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "kat");
    test_known_key(128'h0,
                   128'h62636363_62636363_62636363_62636363,
                   128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e, "zero");
    test_stall();
    test_stall();
    test_key_during_emit();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
